// File: rtl/pll_md_responder.sv
// Responder side of the PLL MD reconfiguration port: register bank, pointer and emulated lock.
// Optional write-protect key in the top register: define PLL_MD_WPROT_EN.
module pll_md_responder #(
  parameter int         NUM_REGS      = 32,
  parameter int         ADDR_W        = 5,
  parameter int         LOCK_CYCLES   = 64,
  parameter logic [7:0] MULTI_FAC_RST = 8'd14
) (
  input  logic       mdclk,
  input  logic       mdrst_n,
  input  logic       reset,
  input  logic [1:0] mdopc,
  input  logic       mdainc,
  input  logic [7:0] mdwdi,
  output logic [7:0] mdrdo,
  output logic       lock,
  output logic [7:0] cfg_mult
);

  localparam logic [1:0] OPC_NOP     = 2'b00;
  localparam logic [1:0] OPC_WRITE   = 2'b01;
  localparam logic [1:0] OPC_READ    = 2'b10;
  localparam logic [1:0] OPC_SETADDR = 2'b11;

  localparam int               CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } lock_state_t;

  lock_state_t                    state_reg, state_next;
  logic [CNT_W-1:0]               cnt_reg, cnt_next;
  logic [ADDR_W-1:0]              ptr_reg, ptr_next;
  logic [7:0]                     mdrdo_reg, mdrdo_next;
  logic [NUM_REGS-1:0][7:0]       bank;
  logic                           lock_int;
  logic                           busy;
  logic                           wr_allowed;
  logic                           wr_accept;
  logic                           disturb;
  logic                           unused_wdi;

  // Only the low ADDR_W bits of mdwdi matter for SETADDR; the rest are deliberately ignored.
  assign unused_wdi = ^mdwdi;

  assign busy    = ~lock_int & ~reset;
  assign bank[0] = {lock_int, busy, 6'b00_0000};

`ifdef PLL_MD_WPROT_EN
  assign wr_allowed = (ptr_reg == ADDR_W'(NUM_REGS - 1)) || (bank[NUM_REGS-1] == 8'hA5);
`else
  assign wr_allowed = 1'b1;
`endif

  // Address 0 is the status register, so writes there never land and never disturb lock.
  assign wr_accept = (mdopc == OPC_WRITE) && (ptr_reg != '0) && wr_allowed;
  assign disturb   = reset | wr_accept;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [7:0] RST_VAL = (gi == 1) ? MULTI_FAC_RST : 8'h00;
      logic [7:0] data_reg;

      always_ff @(posedge mdclk or negedge mdrst_n) begin
        if (!mdrst_n) begin
          data_reg <= RST_VAL;
        end else if (wr_accept && (ptr_reg == ADDR_W'(gi))) begin
          data_reg <= mdwdi;
        end
      end

      assign bank[gi] = data_reg;
    end
  endgenerate

  always_comb begin
    ptr_next   = ptr_reg;
    mdrdo_next = mdrdo_reg;
    case (mdopc)
      OPC_WRITE: begin
        if (mdainc) ptr_next = ptr_reg + ADDR_W'(1);
      end
      OPC_READ: begin
        mdrdo_next = bank[ptr_reg];
        if (mdainc) ptr_next = ptr_reg + ADDR_W'(1);
      end
      OPC_SETADDR: begin
        ptr_next = mdwdi[ADDR_W-1:0];
      end
      default: begin
        ptr_next = ptr_reg;
      end
    endcase
  end

  always_ff @(posedge mdclk or negedge mdrst_n) begin
    if (!mdrst_n) begin
      ptr_reg   <= '0;
      mdrdo_reg <= 8'h00;
    end else begin
      ptr_reg   <= ptr_next;
      mdrdo_reg <= mdrdo_next;
    end
  end

  // Lock emulation: state register.
  always_ff @(posedge mdclk or negedge mdrst_n) begin
    if (!mdrst_n) begin
      state_reg <= ST_ACQUIRE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Lock emulation: next state; the counter freezes once locked.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (disturb) begin
      state_next = ST_ACQUIRE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_ACQUIRE: begin
          if (cnt_reg == CNT_LAST) state_next = ST_LOCKED;
          else                     cnt_next   = cnt_reg + CNT_W'(1);
        end
        ST_LOCKED: begin
          state_next = ST_LOCKED;
        end
        default: begin
          state_next = ST_ACQUIRE;
        end
      endcase
    end
  end

  // Lock emulation: outputs.
  always_comb begin
    lock_int = (state_reg == ST_LOCKED);
  end

  assign lock     = lock_int;
  assign mdrdo    = mdrdo_reg;
  assign cfg_mult = bank[1];

endmodule

// File: tb/tb_pll_md_responder.sv
// Scoreboard bench for pll_md_responder: stimulus queues expected outputs per clock edge,
// a monitor compares them when that edge's outputs are presented.
module tb_pll_md_responder;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] SA  = 2'b11;

  localparam int K_RDO  = 0;
  localparam int K_LOCK = 1;
  localparam int K_CFG  = 2;

`ifdef PLL_MD_WPROT_EN
  localparam logic [7:0] K31 = 8'hA5;
`else
  localparam logic [7:0] K31 = 8'h3C;
`endif

  typedef struct {
    int         cyc;
    bit         at_rst;
    int         kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic       mdclk   = 1'b0;
  logic       mdrst_n = 1'b0;
  logic       reset   = 1'b0;
  logic [1:0] mdopc   = NOP;
  logic       mdainc  = 1'b0;
  logic [7:0] mdwdi   = 8'h00;
  logic [7:0] mdrdo;
  logic       lock;
  logic [7:0] cfg_mult;

  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  pll_md_responder dut (
    .mdclk    (mdclk),
    .mdrst_n  (mdrst_n),
    .reset    (reset),
    .mdopc    (mdopc),
    .mdainc   (mdainc),
    .mdwdi    (mdwdi),
    .mdrdo    (mdrdo),
    .lock     (lock),
    .cfg_mult (cfg_mult)
  );

  always #5 mdclk = ~mdclk;

  always @(posedge mdclk) edge_cnt++;

  function automatic void expect_at(input int cyc, input int kind, input logic [7:0] val,
                                    input string name);
    exp_t x;
    x.cyc    = cyc;
    x.at_rst = 1'b0;
    x.kind   = kind;
    x.val    = val;
    x.name   = name;
    sb_q.push_back(x);
  endfunction

  function automatic void expect_on_rst(input int kind, input logic [7:0] val, input string name);
    exp_t x;
    x.cyc    = -1;
    x.at_rst = 1'b1;
    x.kind   = kind;
    x.val    = val;
    x.name   = name;
    sb_q.push_back(x);
  endfunction

  task automatic check(input exp_t x);
    logic [7:0] act;
    case (x.kind)
      K_RDO:   act = mdrdo;
      K_LOCK:  act = {7'b0, lock};
      default: act = cfg_mult;
    endcase
    n_checks++;
    if (!x.at_rst && (x.cyc != edge_cnt)) begin
      n_fail++;
      $display("FAIL %s: due at edge %0d, sampled late at edge %0d, actual %02h required %02h",
               x.name, x.cyc, edge_cnt, act, x.val);
    end else if (act !== x.val) begin
      n_fail++;
      $display("FAIL %s @edge %0d: actual %02h required %02h", x.name, edge_cnt, act, x.val);
    end else begin
      $display("ok   %s @edge %0d: %02h", x.name, edge_cnt, act);
    end
  endtask

  // Clock-edge monitor: compare everything due at the edge just taken.
  always @(negedge mdclk) begin
    exp_t keep[$];
    keep = {};
    foreach (sb_q[i]) begin
      if (!sb_q[i].at_rst && (sb_q[i].cyc <= edge_cnt)) check(sb_q[i]);
      else                                                keep.push_back(sb_q[i]);
    end
    sb_q = keep;
  end

  // Reset monitor: compare asynchronous reset effects shortly after mdrst_n falls.
  always @(negedge mdrst_n) begin
    exp_t keep[$];
    #1;
    keep = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].at_rst) check(sb_q[i]);
      else                keep.push_back(sb_q[i]);
    end
    sb_q = keep;
  end

  task automatic issue(input logic [1:0] opc, input logic ainc, input logic [7:0] wdi,
                       output int e);
    @(posedge mdclk);
    #1;
    mdopc  = opc;
    mdainc = ainc;
    mdwdi  = wdi;
    e      = edge_cnt + 1;
  endtask

  task automatic idle_through(input int target);
    int d;
    while (edge_cnt + 1 < target) issue(NOP, 1'b0, 8'h00, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, actual edge %0d required completion", edge_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    int r, r2, e, ew, ew3, er, el, d;

    // Reset state and first lock after release.
    repeat (3) @(posedge mdclk);
    #1;
    mdrst_n = 1'b1;
    r = edge_cnt;
    expect_at(r, K_RDO, 8'h00, "rst_mdrdo");
    expect_at(r, K_LOCK, 8'h00, "rst_lock");
    expect_at(r, K_CFG, 8'd14, "rst_cfg");
    for (int i = 1; i < 64; i++) expect_at(r + i, K_LOCK, 8'h00, "acq_lock0");
    expect_at(r + 64, K_LOCK, 8'h01, "first_lock");
    expect_at(r + 64, K_CFG, 8'd14, "cfg_default");
    expect_at(r + 64, K_RDO, 8'h00, "mdrdo_idle");
    idle_through(r + 64);
    issue(RD, 1'b0, 8'h00, e);
    expect_at(e, K_RDO, 8'h80, "status_locked");

`ifdef PLL_MD_WPROT_EN
    // Protected write before the key is loaded.
    issue(SA, 1'b0, 8'h01, d);
    issue(WR, 1'b0, 8'h77, e);
    expect_at(e, K_CFG, 8'd14, "wprot_blocked_cfg");
    expect_at(e, K_LOCK, 8'h01, "wprot_lock_kept");
    expect_at(e + 1, K_LOCK, 8'h01, "wprot_lock_kept2");
    issue(SA, 1'b0, 8'h1F, d);
    issue(WR, 1'b0, 8'hA5, e);
    expect_at(e, K_LOCK, 8'h00, "key_write_disturbs");
`endif

    // Multiplier write with post-increment, then relock.
    issue(SA, 1'b0, 8'h02, d);
    issue(WR, 1'b0, 8'h5A, e);
    expect_at(e, K_LOCK, 8'h00, "wr2_lock_drop");
    issue(SA, 1'b1, 8'h01, d);
    issue(WR, 1'b1, 8'h1C, ew);
    expect_at(ew - 1, K_CFG, 8'd14, "cfg_before_wr");
    expect_at(ew, K_CFG, 8'h1C, "cfg_after_wr");
    expect_at(ew, K_LOCK, 8'h00, "wr1_lock_drop");
    expect_at(ew + 63, K_LOCK, 8'h00, "wr1_still_acq");
    expect_at(ew + 64, K_LOCK, 8'h01, "wr1_relock");
    issue(RD, 1'b0, 8'h00, e);
    expect_at(e, K_RDO, 8'h5A, "rd_ptr2");
    issue(NOP, 1'b1, 8'h00, e);
    expect_at(e, K_RDO, 8'h5A, "mdrdo_held");
    idle_through(ew + 64);

    // Pointer wrap from the top register; SETADDR ignores upper bits and mdainc.
    issue(SA, 1'b0, 8'h1F, d);
    issue(WR, 1'b0, K31, ew3);
    expect_at(ew3, K_LOCK, 8'h00, "wr31_lock_drop");
    issue(SA, 1'b1, 8'hFF, d);
    issue(RD, 1'b1, 8'h00, e);
    expect_at(e, K_RDO, K31, "rd_reg31");
    issue(RD, 1'b0, 8'h00, e);
    expect_at(e, K_RDO, 8'h40, "rd_wrap_status");
    expect_at(ew3 + 63, K_LOCK, 8'h00, "wr31_still_acq");
    expect_at(ew3 + 64, K_LOCK, 8'h01, "wr31_relock");
    idle_through(ew3 + 64);

    // Writes to the status register are discarded but still honour mdainc.
    issue(WR, 1'b0, 8'hFF, e);
    expect_at(e, K_LOCK, 8'h01, "wr0_no_disturb");
    issue(RD, 1'b0, 8'h00, e);
    expect_at(e, K_RDO, 8'h80, "status_unchanged");
    expect_at(e, K_LOCK, 8'h01, "wr0_lock_kept");
    issue(WR, 1'b1, 8'hFF, e);
    expect_at(e, K_LOCK, 8'h01, "wr0_ainc_no_dist");
    issue(RD, 1'b0, 8'h00, e);
    expect_at(e, K_RDO, 8'h1C, "wr0_ainc_ptr1");
    issue(NOP, 1'b1, 8'h00, d);
    issue(RD, 1'b0, 8'h00, e);
    expect_at(e, K_RDO, 8'h1C, "nop_ainc_ignored");
    expect_at(e, K_CFG, 8'h1C, "cfg_kept");

    // PLL reset request holds lock low and clears busy.
    issue(SA, 1'b0, 8'h00, d);
    issue(NOP, 1'b0, 8'h00, er);
    reset = 1'b1;
    expect_at(er, K_LOCK, 8'h00, "reset_lock_drop");
    issue(RD, 1'b0, 8'h00, e);
    expect_at(e, K_RDO, 8'h00, "status_in_reset");
    el = e;
    repeat (3) begin
      issue(NOP, 1'b0, 8'h00, el);
      expect_at(el, K_LOCK, 8'h00, "reset_hold_lock");
    end
    expect_at(el, K_CFG, 8'h1C, "cfg_survives_reset");
    issue(NOP, 1'b0, 8'h00, e);
    reset = 1'b0;
    expect_at(el + 63, K_LOCK, 8'h00, "post_reset_acq");
    expect_at(el + 64, K_LOCK, 8'h01, "post_reset_lock");
    idle_through(el + 64);

    // Asynchronous mdrst_n in the middle of a write.
    issue(SA, 1'b0, 8'h01, d);
    issue(WR, 1'b0, 8'h99, ew);
    expect_at(ew, K_CFG, 8'h99, "cfg_99");
    expect_at(ew, K_LOCK, 8'h00, "wr99_lock_drop");
    issue(RD, 1'b0, 8'h00, e);
    expect_at(e, K_RDO, 8'h99, "rd_99");
    issue(NOP, 1'b0, 8'h00, d);
    @(posedge mdclk);
    #1;
    mdopc  = WR;
    mdainc = 1'b1;
    mdwdi  = 8'h55;
    expect_on_rst(K_RDO, 8'h00, "async_rst_mdrdo");
    expect_on_rst(K_LOCK, 8'h00, "async_rst_lock");
    expect_on_rst(K_CFG, 8'd14, "async_rst_cfg");
    #2;
    mdrst_n = 1'b0;
    @(posedge mdclk);
    #1;
    mdopc  = NOP;
    mdainc = 1'b0;
    mdwdi  = 8'h00;
    @(posedge mdclk);
    #1;
    mdrst_n = 1'b1;
    r2 = edge_cnt;
    expect_at(r2, K_CFG, 8'd14, "cfg_after_rst");
    issue(RD, 1'b1, 8'h00, e);
    expect_at(e, K_RDO, 8'h40, "status_after_rst");
    issue(RD, 1'b0, 8'h00, e);
    expect_at(e, K_RDO, 8'd14, "reg1_after_rst");
    expect_at(r2 + 63, K_LOCK, 8'h00, "rst2_acq");
    expect_at(r2 + 64, K_LOCK, 8'h01, "rst2_lock");
    idle_through(r2 + 66);

    @(negedge mdclk);
    #1;
    foreach (sb_q[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: never sampled, actual none required %02h at edge %0d",
               sb_q[i].name, sb_q[i].val, sb_q[i].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_md_responder.md
Name: pll_md_responder

Overview:
- Responder end of the PLL dynamic-reconfiguration (MD) port: the side that accepts mdopc/mdainc/mdwdi commands from the PLL initialisation sequencer and returns mdrdo.
- Holds an 8-bit register bank addressed through an internal auto-incrementing pointer.
- Models PLL reset/lock behaviour, so the sequencer and the clock tree can run in simulation and on parts without a reconfigurable PLL.
- Sits between the PLL init sequencer and the clock wrapper, in place of the hard PLL MD port.

Parameters:
- NUM_REGS, 32, number of 8-bit registers; must be a power of two, 2..256.
- ADDR_W, 5, pointer width; equals log2(NUM_REGS).
- LOCK_CYCLES, 64, mdclk cycles from the end of a disturbance to lock=1; must be at least 2.
- MULTI_FAC_RST, 8'd14, reset value of register 1 (feedback multiplier).

Ports:
- mdclk, input, 1, the single clock; all logic is on its rising edge.
- mdrst_n, input, 1, asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to mdclk.
- reset, input, 1, PLL reset request from the sequencer; active high, sampled on mdclk.
- mdopc, input, 2, opcode: 00 NOP, 01 WRITE, 10 READ, 11 SETADDR.
- mdainc, input, 1, post-increment the pointer after a WRITE or READ.
- mdwdi, input, 8, write data for WRITE, or the new address for SETADDR.
- mdrdo, output, 8, read data.
- lock, output, 1, emulated PLL lock.
- cfg_mult, output, 8, current contents of register 1, for downstream clock-divider logic.

Behaviour:
- Reset (mdrst_n=0):
  - ptr=0; mdrdo=0; lock=0; lock counter=0.
  - reg[1]=MULTI_FAC_RST; all other registers =0.
  - cfg_mult=MULTI_FAC_RST.
  - Reset mid-command aborts the command: no partial write, no increment.
- Commands are sampled once per mdclk edge; there is no handshake and a new command is accepted every cycle.
- WRITE:
  - reg[ptr] <= mdwdi at that edge; readable on the next cycle.
  - reg[0] is the read-only status register; a WRITE to ptr=0 is discarded, but mdainc still applies.
- READ:
  - mdrdo <= reg[ptr] at that edge, so data is valid 1 cycle after the READ and held until the next READ.
  - Reading ptr=0 returns the status register: {lock, busy, 6'b0}, where busy = ~lock & ~reset.
- SETADDR:
  - ptr <= mdwdi[ADDR_W-1:0]; upper bits are ignored.
  - mdainc is ignored for this opcode.
- NOP: no state change; mdainc is ignored.
- Increment: with WRITE or READ and mdainc=1, ptr <= ptr+1, wrapping from NUM_REGS-1 to 0. The access always uses the pre-increment ptr.
- Lock model:
  - Disturbance = reset=1, or an accepted WRITE to ptr>=1.
  - A disturbance forces lock=0 and counter=0 in that cycle.
  - Otherwise the counter increments while lock=0.
  - When counter==LOCK_CYCLES-1, lock <= 1 on the next edge and the counter stops.
  - lock falls on the edge after a disturbance; the first lock after reset release comes LOCK_CYCLES edges after release, provided reset=0.
- Holding reset=1 keeps lock=0 indefinitely. Register contents and pointer are unaffected by reset (only mdrst_n clears them).
- cfg_mult is reg[1], registered, and updates on the same edge as the write.

Optional Feature:
- Macro: PLL_MD_WPROT_EN.
- When defined:
  - reg[NUM_REGS-1] is the write-protect key.
  - Writes to addresses 1..NUM_REGS-2 take effect only while that register holds 8'hA5; otherwise they are discarded and do not disturb lock.
  - The key register itself is always writable.
- When not defined: no protection; reg[NUM_REGS-1] is an ordinary register.

Test Plan:
- Release mdrst_n with reset=0 -> lock=0 for 63 edges, lock=1 on the 64th edge; cfg_mult=14; READ at ptr=0 gives mdrdo=8'h80 one cycle later.
- SETADDR 8'h01, then WRITE 8'h1C with mdainc=1 -> cfg_mult=8'h1C next cycle; ptr=2; lock drops next edge and returns 64 edges later.
- SETADDR 8'h1F, READ with mdainc=1, then READ -> reads come from addresses 31 then 0; second mdrdo = status byte.
- WRITE 8'hFF at ptr=0 -> status unchanged; lock not disturbed; ptr unchanged with mdainc=0.
- Assert mdrst_n low one cycle after a WRITE to ptr=1 is issued -> all outputs return to reset values asynchronously; cfg_mult=14.
- With PLL_MD_WPROT_EN: WRITE to ptr=1 before the key -> ignored, lock stays 1; write 8'hA5 to reg 31, retry -> cfg_mult updates and lock drops.
